// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, requester IDs and default widths.
package sram_arb_pkg;

   localparam int MEMORY_DATA_WIDTH = 8;
   localparam int MEMORY_ADDR_WIDTH = 9;
   localparam int STARVE_LIMIT_DEF  = 4;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ACC  = 2'd1,
      ARB_RDAT = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_IO  = 1'b0,
      REQ_CPU = 1'b1
   } req_id_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select between the IO and CPU requesters.
// GNT bit 0 is the IO grant, bit 1 the CPU grant; at most one bit is set.
module sram_arb_pick
   import sram_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int SW           = 3
)(
   input  logic          EN,
   input  logic          IO_REQ,
   input  logic          CPU_REQ,
   input  logic          MODE,
   input  req_id_t       LAST,
   input  logic [SW-1:0] STARVE,
   output logic [1:0]    GNT
);

   logic io_win;

   always_comb begin
      io_win = 1'b0;
      if (IO_REQ) begin
         if (!CPU_REQ)
            io_win = 1'b1;
         else if (MODE)
            // Fixed priority, but hand one slot to the CPU once it has waited long enough.
            io_win = (STARVE != SW'(STARVE_LIMIT));
         else
            io_win = (LAST == REQ_CPU);
      end
      GNT = 2'b00;
      if (EN)
         GNT = {CPU_REQ && !io_win, io_win};
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port registered-read SRAM between the IO loader and the CPU.
// Handshake: a request is accepted at the posedge where REQ and GNT are both high; VLD pulses once per accepted access.
module sram_port_arbiter #(
   parameter int MEMORY_DATA_WIDTH = sram_arb_pkg::MEMORY_DATA_WIDTH,
   parameter int MEMORY_ADDR_WIDTH = sram_arb_pkg::MEMORY_ADDR_WIDTH,
   parameter int STARVE_LIMIT      = sram_arb_pkg::STARVE_LIMIT_DEF
)(
   input  logic                         CLK,
   input  logic                         BGN,
   input  logic                         MODE,
   input  logic                         IO_REQ,
   input  logic                         IO_WE,
   input  logic [MEMORY_ADDR_WIDTH-1:0] IO_A,
   input  logic [MEMORY_DATA_WIDTH-1:0] IO_D,
   output logic                         IO_GNT,
   output logic                         IO_VLD,
   output logic [MEMORY_DATA_WIDTH-1:0] IO_Q,
   input  logic                         CPU_REQ,
   input  logic                         CPU_WE,
   input  logic [MEMORY_ADDR_WIDTH-1:0] CPU_A,
   input  logic [MEMORY_DATA_WIDTH-1:0] CPU_D,
   output logic                         CPU_GNT,
   output logic                         CPU_VLD,
   output logic [MEMORY_DATA_WIDTH-1:0] CPU_Q,
   output logic                         BUSY,
   output logic [1:0]                   DBG_STATE,
   output logic                         CEN,
   output logic                         WEN,
   output logic [MEMORY_ADDR_WIDTH-1:0] A,
   output logic [MEMORY_DATA_WIDTH-1:0] D,
   input  logic [MEMORY_DATA_WIDTH-1:0] Q
);

   import sram_arb_pkg::*;

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_t                   state_q, state_d;
   logic [1:0]                   gnt;
   logic                         granted;
   req_id_t                      win;
   logic                         win_we;
   logic [MEMORY_ADDR_WIDTH-1:0] win_a;
   logic [MEMORY_DATA_WIDTH-1:0] win_d;

   req_id_t                      owner_q, last_q;
   logic                         we_q;
   logic [SW-1:0]                starve_q;
   logic                         cen_q, wen_q, io_vld_q, cpu_vld_q;
   logic [MEMORY_ADDR_WIDTH-1:0] a_q;
   logic [MEMORY_DATA_WIDTH-1:0] d_q, io_q_q, cpu_q_q;

   sram_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .SW           (SW)
   ) u_pick (
      .EN      (BGN && (state_q == ARB_IDLE)),
      .IO_REQ  (IO_REQ),
      .CPU_REQ (CPU_REQ),
      .MODE    (MODE),
      .LAST    (last_q),
      .STARVE  (starve_q),
      .GNT     (gnt)
   );

   assign granted = |gnt;
   assign win     = gnt[1] ? REQ_CPU : REQ_IO;
   assign win_we  = gnt[1] ? CPU_WE  : IO_WE;
   assign win_a   = gnt[1] ? CPU_A   : IO_A;
   assign win_d   = gnt[1] ? CPU_D   : IO_D;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: if (granted) state_d = ARB_ACC;
         ARB_ACC:  state_d = we_q ? ARB_IDLE : ARB_RDAT;
         ARB_RDAT: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge BGN) begin
      if (!BGN) state_q <= ARB_IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge CLK or negedge BGN) begin
      if (!BGN) begin
         owner_q   <= REQ_IO;
         last_q    <= REQ_CPU;
         we_q      <= 1'b0;
         starve_q  <= '0;
         cen_q     <= 1'b1;
         wen_q     <= 1'b1;
         a_q       <= '0;
         d_q       <= '0;
         io_vld_q  <= 1'b0;
         cpu_vld_q <= 1'b0;
         io_q_q    <= '0;
         cpu_q_q   <= '0;
      end else begin
         // SRAM pins idle by default so A/D read as zero whenever CEN is high.
         cen_q     <= 1'b1;
         wen_q     <= 1'b1;
         a_q       <= '0;
         d_q       <= '0;
         io_vld_q  <= 1'b0;
         cpu_vld_q <= 1'b0;
         if (granted) begin
            owner_q <= win;
            last_q  <= win;
            we_q    <= win_we;
            cen_q   <= 1'b0;
            wen_q   <= !win_we;
            a_q     <= win_a;
            d_q     <= win_we ? win_d : '0;
         end
         if (state_q == ARB_ACC && we_q) begin
            if (owner_q == REQ_CPU) cpu_vld_q <= 1'b1;
            else                    io_vld_q  <= 1'b1;
         end
         if (state_q == ARB_RDAT) begin
            if (owner_q == REQ_CPU) begin
               cpu_q_q   <= Q;
               cpu_vld_q <= 1'b1;
            end else begin
               io_q_q    <= Q;
               io_vld_q  <= 1'b1;
            end
         end
         if (!CPU_REQ || gnt[1])
            starve_q <= '0;
         else if (gnt[0] && starve_q != SW'(STARVE_LIMIT))
            starve_q <= starve_q + SW'(1);
      end
   end

   assign IO_GNT    = gnt[0];
   assign CPU_GNT   = gnt[1];
   assign IO_VLD    = io_vld_q;
   assign CPU_VLD   = cpu_vld_q;
   assign IO_Q      = io_q_q;
   assign CPU_Q     = cpu_q_q;
   assign BUSY      = (state_q != ARB_IDLE);
   assign DBG_STATE = state_q;
   assign CEN       = cen_q;
   assign WEN       = wen_q;
   assign A         = a_q;
   assign D         = d_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: SRAM model, driver tasks, negedge scoreboard monitor.
module tb_sram_port_arbiter;

   localparam int DW = 8;
   localparam int AW = 9;

   logic          CLK = 1'b0;
   logic          BGN = 1'b1;
   logic          MODE = 1'b0;
   logic          IO_REQ = 1'b0, IO_WE = 1'b0;
   logic [AW-1:0] IO_A = '0;
   logic [DW-1:0] IO_D = '0;
   logic          CPU_REQ = 1'b0, CPU_WE = 1'b0;
   logic [AW-1:0] CPU_A = '0;
   logic [DW-1:0] CPU_D = '0;
   logic          IO_GNT, IO_VLD, CPU_GNT, CPU_VLD, BUSY, CEN, WEN;
   logic [DW-1:0] IO_Q, CPU_Q, D;
   logic [DW-1:0] SQ = '0;
   logic [AW-1:0] A;
   logic [1:0]    DBG_STATE;

   sram_port_arbiter dut (
      .CLK(CLK), .BGN(BGN), .MODE(MODE),
      .IO_REQ(IO_REQ), .IO_WE(IO_WE), .IO_A(IO_A), .IO_D(IO_D),
      .IO_GNT(IO_GNT), .IO_VLD(IO_VLD), .IO_Q(IO_Q),
      .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_A(CPU_A), .CPU_D(CPU_D),
      .CPU_GNT(CPU_GNT), .CPU_VLD(CPU_VLD), .CPU_Q(CPU_Q),
      .BUSY(BUSY), .DBG_STATE(DBG_STATE),
      .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(SQ)
   );

   // clock / reset
   always #5 CLK = ~CLK;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // SRAM model: registered read, contents zero except 0x1A5 = 0x3C
   logic [DW-1:0] mem [0:(1<<AW)-1];
   bit mem_init = 1'b0;
   always @(posedge CLK) begin
      if (!mem_init) begin
         for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
         mem[9'h1A5] = 8'h3C;
         mem_init = 1'b1;
      end else if (!CEN) begin
         if (!WEN) mem[A] = D;
         else      SQ <= mem[A];
      end
   end

   // scoreboard
   int checks = 0;
   int failures = 0;
   logic [8:0] exp_io_q[$];
   logic [8:0] exp_cpu_q[$];
   logic       exp_gnt_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   int            busy_cnt = 0;
   bit            acc_due = 1'b0, vld_due = 1'b0;
   logic          exp_wen;
   logic [AW-1:0] exp_a;
   logic [DW-1:0] exp_d;
   logic [DW-1:0] io_model = '0, cpu_model = '0;

   always @(negedge CLK) begin : monitor
      logic [8:0] e;
      logic       gid, gwe;
      if (!BGN) begin
         chk("reset_pins", 32'({CEN, WEN, A, D, IO_GNT, CPU_GNT, IO_VLD, CPU_VLD, BUSY}), 32'h00C0_0000);
         chk("reset_q", 32'({IO_Q, CPU_Q}), 32'h0);
         exp_io_q.delete();
         exp_cpu_q.delete();
         busy_cnt = 0; acc_due = 1'b0; vld_due = 1'b0;
         io_model = '0; cpu_model = '0;
      end else begin
         chk("vld_timing", 32'(IO_VLD | CPU_VLD), 32'(vld_due));
         vld_due = 1'b0;
         chk("vld_exclusive", 32'(IO_VLD & CPU_VLD), 32'h0);
         if (IO_VLD) begin
            if (exp_io_q.size() == 0) chk("io_vld_spurious", 32'(IO_VLD), 32'h0);
            else begin
               e = exp_io_q.pop_front();
               if (e[8]) io_model = e[7:0];
            end
         end
         if (CPU_VLD) begin
            if (exp_cpu_q.size() == 0) chk("cpu_vld_spurious", 32'(CPU_VLD), 32'h0);
            else begin
               e = exp_cpu_q.pop_front();
               if (e[8]) cpu_model = e[7:0];
            end
         end
         chk("io_q", 32'(IO_Q), 32'(io_model));
         chk("cpu_q", 32'(CPU_Q), 32'(cpu_model));
         chk("cen_window", 32'(CEN), 32'(!acc_due));
         if (acc_due && !CEN) chk("acc_pins", 32'({WEN, A, D}), 32'({exp_wen, exp_a, exp_d}));
         if (CEN) chk("idle_pins", 32'({A, D}), 32'h0);
         chk("busy", 32'(BUSY), 32'(busy_cnt > 0));
         acc_due = 1'b0;
         if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) vld_due = 1'b1;
         end
         chk("gnt_exclusive", 32'(IO_GNT & CPU_GNT), 32'h0);
         if ((IO_GNT && IO_REQ) || (CPU_GNT && CPU_REQ)) begin
            gid = CPU_GNT;
            if (exp_gnt_q.size() == 0) chk("gnt_spurious", 32'({CPU_GNT, IO_GNT}), 32'h0);
            else chk("gnt_order", 32'(gid), 32'(exp_gnt_q.pop_front()));
            gwe      = gid ? CPU_WE : IO_WE;
            exp_wen  = !gwe;
            exp_a    = gid ? CPU_A : IO_A;
            exp_d    = gwe ? (gid ? CPU_D : IO_D) : '0;
            acc_due  = 1'b1;
            busy_cnt = gwe ? 1 : 2;
         end
      end
   end

   // driver tasks: called at posedge+#1, return at posedge+#1 after the accepting edge
   task automatic issue(input bit cpu, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_rd, output int gcyc);
      bit seen = 1'b0;
      exp_gnt_q.push_back(cpu);
      if (cpu) exp_cpu_q.push_back({!we, exp_rd});
      else     exp_io_q.push_back({!we, exp_rd});
      if (cpu) begin CPU_WE = we; CPU_A = a; CPU_D = d; CPU_REQ = 1'b1; end
      else     begin IO_WE = we;  IO_A = a;  IO_D = d;  IO_REQ = 1'b1;  end
      for (int k = 0; k < 30; k++) begin
         @(negedge CLK);
         if (cpu ? CPU_GNT : IO_GNT) begin seen = 1'b1; break; end
      end
      @(posedge CLK);
      #1;
      gcyc = cyc;
      if (cpu) CPU_REQ = 1'b0;
      else     IO_REQ = 1'b0;
      chk("issue_granted", 32'(seen), 32'h1);
   endtask

   // Holds the given REQ levels until the listed grant sequence (I/C, writes) has been accepted.
   task automatic hold(input bit io_r, input bit cpu_r, input string seq);
      for (int i = 0; i < seq.len(); i++) begin
         if (seq[i] == "C") begin exp_gnt_q.push_back(1'b1); exp_cpu_q.push_back(9'h000); end
         else               begin exp_gnt_q.push_back(1'b0); exp_io_q.push_back(9'h000);  end
      end
      IO_REQ = io_r;
      CPU_REQ = cpu_r;
      for (int k = 0; k < 8 * seq.len(); k++) begin
         @(posedge CLK);
         if (exp_gnt_q.size() == 0) break;
      end
      #1;
      chk("hold_done", 32'(exp_gnt_q.size()), 32'h0);
      exp_gnt_q.delete();
   endtask

   initial begin
      int g0, g1, g2, g3, gx;
      #1 BGN = 1'b0;
      repeat (3) @(posedge CLK);
      #1 BGN = 1'b1;

      // reset during a read aborts it, then a clean read of 0x1A5
      issue(1'b0, 1'b0, 9'h1A5, 8'h00, 8'h3C, gx);
      BGN = 1'b0;
      #1;
      chk("abort_cen", 32'(CEN), 32'h1);
      chk("abort_a", 32'(A), 32'h0);
      repeat (2) @(posedge CLK);
      #1 BGN = 1'b1;
      issue(1'b0, 1'b0, 9'h1A5, 8'h00, 8'h3C, gx);

      // CPU write then readback
      issue(1'b1, 1'b1, 9'h0FF, 8'hA5, 8'h00, gx);
      issue(1'b1, 1'b0, 9'h0FF, 8'h00, 8'hA5, gx);

      // round-robin with both requesting; last grant was CPU so IO goes first
      IO_WE = 1'b1; IO_A = 9'h010; IO_D = 8'h11;
      CPU_WE = 1'b1; CPU_A = 9'h020; CPU_D = 8'h22;
      MODE = 1'b0;
      hold(1'b1, 1'b1, "ICICIC");

      // IO priority with starvation guard; dropping CPU_REQ clears the count
      MODE = 1'b1;
      hold(1'b1, 1'b1, "IIIICIIIICII");
      hold(1'b1, 1'b0, "III");
      hold(1'b1, 1'b1, "IIIIC");
      IO_REQ = 1'b0; CPU_REQ = 1'b0;

      // back-to-back IO writes, one grant every 2 cycles
      MODE = 1'b0;
      issue(1'b0, 1'b1, 9'h000, 8'h50, 8'h00, g0);
      issue(1'b0, 1'b1, 9'h001, 8'h51, 8'h00, g1);
      issue(1'b0, 1'b1, 9'h002, 8'h52, 8'h00, g2);
      issue(1'b0, 1'b1, 9'h003, 8'h53, 8'h00, g3);
      chk("b2b_gap01", 32'(g1 - g0), 32'd2);
      chk("b2b_gap12", 32'(g2 - g1), 32'd2);
      chk("b2b_gap23", 32'(g3 - g2), 32'd2);
      issue(1'b0, 1'b0, 9'h002, 8'h00, 8'h52, gx);

      // IO_REQ pulsed while busy must not be granted or reach the SRAM
      issue(1'b1, 1'b0, 9'h003, 8'h00, 8'h53, gx);
      IO_WE = 1'b1; IO_A = 9'h1FF; IO_D = 8'h77; IO_REQ = 1'b1;
      @(posedge CLK);
      #1 IO_REQ = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      issue(1'b0, 1'b0, 9'h1FF, 8'h00, 8'h00, gx);

      repeat (6) @(posedge CLK);
      #1;
      chk("drain", 32'(exp_gnt_q.size() + exp_io_q.size() + exp_cpu_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
